// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD SPI decoder: command opcodes, command FSM
// state encoding and an opcode-to-state helper.
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_RASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_RASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } lcd_state_e;

    // Every command byte selects a new state; unknown opcodes (and NOP)
    // park the FSM in SKIP so their argument bytes are ignored.
    function automatic lcd_state_e opcode_to_state(input logic [7:0] op);
        case (op)
            OP_CASET: return ST_CASET;
            OP_RASET: return ST_RASET;
            OP_RAMWR: return ST_RAMWR;
            default:  return ST_SKIP;
        endcase
    endfunction

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// ---------------------------------------------------------------------------
// lcd_spi_byte_rx
// Oversampling SPI byte receiver. All SPI pins are brought into the clk
// domain through two-flop synchronizers; the sampling edge is detected on
// the synchronized spi_clk and bits are shifted MSB first.
//
// Ports
//   clk, resn           system clock, asynchronous active-low reset
//   spi_*               raw SPI pins (asynchronous to clk)
//   rx_done             combinational: a byte completes on the next clk edge
//   rx_data, rx_dc      combinational byte/dc belonging to rx_done
//   spi_resn_sync       synchronized display reset (active low)
//   byte_valid          registered one-cycle strobe per byte
//   byte_data, byte_dc  registered byte and dc, held between strobes
// ---------------------------------------------------------------------------
module lcd_spi_byte_rx
    import lcd_pkg::*;
#(
    parameter int c_sample_rising = 1
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_resn,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       spi_resn_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    // Synchronizer bit order: {csn, clk, mosi, dc, resn}. Idle values keep
    // the receiver deselected and the display out of reset.
    localparam logic [4:0] SYNC_IDLE = 5'b10001;
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    logic [4:0] sync1_q, sync2_q;
    logic       clk_prev_q;
    logic       edge_q, edge_d;
    logic       bit_q, bit_d;
    logic       dc_q, dc_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;

    logic csn_s, sclk_s, mosi_s, dc_s, resn_s;
    logic sample_edge, abort;

    always_comb begin
        csn_s  = sync2_q[4];
        sclk_s = sync2_q[3];
        mosi_s = sync2_q[2];
        dc_s   = sync2_q[1];
        resn_s = sync2_q[0];

        if (c_sample_rising != 0) sample_edge = sclk_s & ~clk_prev_q;
        else                      sample_edge = ~sclk_s & clk_prev_q;

        // A deselect or display reset throws away any partial byte.
        abort = csn_s | ~resn_s;

        // Sample stage: capture the bit that belongs to the detected edge.
        edge_d = sample_edge & ~abort;
        bit_d  = mosi_s;
        dc_d   = dc_s;

        // Shift stage: the 8th bit completes the byte.
        rx_done = edge_q & ~abort & (cnt_q == LAST_BIT);
        rx_data = {shift_q, bit_q};
        rx_dc   = dc_q;

        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (edge_q) begin
            shift_d = {shift_q[5:0], bit_q};
            cnt_d   = cnt_q + 3'd1;
        end

        byte_valid_d = rx_done;
        byte_data_d  = rx_done ? rx_data : byte_data_q;
        byte_dc_d    = rx_done ? rx_dc   : byte_dc_q;
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sync1_q      <= SYNC_IDLE;
            sync2_q      <= SYNC_IDLE;
            clk_prev_q   <= 1'b0;
            edge_q       <= 1'b0;
            bit_q        <= 1'b0;
            dc_q         <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
        end else begin
            sync1_q      <= {spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn};
            sync2_q      <= sync1_q;
            clk_prev_q   <= sclk_s;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            dc_q         <= dc_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
        end
    end

    assign spi_resn_sync = sync2_q[0];
    assign byte_valid    = byte_valid_q;
    assign byte_data     = byte_data_q;
    assign byte_dc       = byte_dc_q;

endmodule

// File: rtl/lcd_spi_decoder.sv
// ---------------------------------------------------------------------------
// lcd_spi_decoder
// Decodes an ST7789-style SPI command stream (CASET / RASET / RAMWR) into
// byte strobes and RGB565 pixel writes with screen coordinates.
//
// Ports
//   clk, resn        system clock (>= 4x spi_clk), async active-low reset
//   spi_csn/clk/mosi/dc/resn   raw SPI display pins
//   byte_valid, byte_data, byte_dc            per-byte strobe and contents
//   pixel_valid, pixel_x, pixel_y, pixel_color   per-pixel strobe and contents
// ---------------------------------------------------------------------------
module lcd_spi_decoder
    import lcd_pkg::*;
#(
    parameter int c_x_size        = 240,
    parameter int c_y_size        = 240,
    parameter int c_x_bits        = $clog2(c_x_size),
    parameter int c_y_bits        = $clog2(c_y_size),
    parameter int c_sample_rising = 1
) (
    input  logic                clk,
    input  logic                resn,
    input  logic                spi_csn,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    input  logic                spi_dc,
    input  logic                spi_resn,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    output logic                byte_dc,
    output logic                pixel_valid,
    output logic [c_x_bits-1:0] pixel_x,
    output logic [c_y_bits-1:0] pixel_y,
    output logic [15:0]         pixel_color
);

    localparam logic [15:0] X_LAST = 16'(c_x_size - 1);
    localparam logic [15:0] Y_LAST = 16'(c_y_size - 1);

    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_resn;

    lcd_spi_byte_rx #(
        .c_sample_rising (c_sample_rising)
    ) u_byte_rx (
        .clk           (clk),
        .resn          (resn),
        .spi_csn       (spi_csn),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_dc        (spi_dc),
        .spi_resn      (spi_resn),
        .rx_done       (rx_done),
        .rx_data       (rx_data),
        .rx_dc         (rx_dc),
        .spi_resn_sync (rx_resn),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_dc       (byte_dc)
    );

    lcd_state_e          state_q, state_d;
    logic [1:0]          arg_idx_q, arg_idx_d;
    logic                toggle_q, toggle_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         xs_q, xs_d, xe_q, xe_d;
    logic [15:0]         ys_q, ys_d, ye_q, ye_d;
    logic [15:0]         px_q, px_d, py_q, py_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic [c_x_bits-1:0] pixel_x_q, pixel_x_d;
    logic [c_y_bits-1:0] pixel_y_q, pixel_y_d;
    logic [15:0]         pixel_color_q, pixel_color_d;

    always_comb begin
        state_d       = state_q;
        arg_idx_d     = arg_idx_q;
        toggle_d      = toggle_q;
        hi_d          = hi_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        px_d          = px_q;
        py_d          = py_q;
        pixel_valid_d = 1'b0;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_color_d = pixel_color_q;

        if (!rx_resn) begin
            // Display reset restores the full-screen window; outputs hold.
            state_d   = ST_IDLE;
            arg_idx_d = '0;
            toggle_d  = 1'b0;
            xs_d      = '0;
            xe_d      = X_LAST;
            ys_d      = '0;
            ye_d      = Y_LAST;
            px_d      = '0;
            py_d      = '0;
        end else if (rx_done) begin
            if (!rx_dc) begin
                state_d   = opcode_to_state(rx_data);
                arg_idx_d = '0;
                toggle_d  = 1'b0;
                if (rx_data == OP_RAMWR) begin
                    px_d = xs_q;
                    py_d = ys_q;
                end
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (state_q == ST_CASET) begin
                            case (arg_idx_q)
                                2'd0:    xs_d[15:8] = rx_data;
                                2'd1:    xs_d[7:0]  = rx_data;
                                2'd2:    xe_d[15:8] = rx_data;
                                default: xe_d[7:0]  = rx_data;
                            endcase
                        end else begin
                            case (arg_idx_q)
                                2'd0:    ys_d[15:8] = rx_data;
                                2'd1:    ys_d[7:0]  = rx_data;
                                2'd2:    ye_d[15:8] = rx_data;
                                default: ye_d[7:0]  = rx_data;
                            endcase
                        end
                        // After the 4th argument any surplus bytes are ignored.
                        if (arg_idx_q == 2'd3) state_d = ST_SKIP;
                        arg_idx_d = arg_idx_q + 2'd1;
                    end
                    ST_RAMWR: begin
                        if (!toggle_q) begin
                            hi_d     = rx_data;
                            toggle_d = 1'b1;
                        end else begin
                            toggle_d      = 1'b0;
                            pixel_valid_d = 1'b1;
                            pixel_color_d = {hi_q, rx_data};
                            pixel_x_d     = px_q[c_x_bits-1:0];
                            pixel_y_d     = py_q[c_y_bits-1:0];
                            // Raster advance within the window, wrapping to its origin.
                            if (px_q == xe_q) begin
                                px_d = xs_q;
                                py_d = (py_q == ye_q) ? ys_q : py_q + 16'd1;
                            end else begin
                                px_d = px_q + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q       <= ST_IDLE;
            arg_idx_q     <= '0;
            toggle_q      <= 1'b0;
            hi_q          <= '0;
            xs_q          <= '0;
            xe_q          <= X_LAST;
            ys_q          <= '0;
            ye_q          <= Y_LAST;
            px_q          <= '0;
            py_q          <= '0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_color_q <= '0;
        end else begin
            state_q       <= state_d;
            arg_idx_q     <= arg_idx_d;
            toggle_q      <= toggle_d;
            hi_q          <= hi_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            px_q          <= px_d;
            py_q          <= py_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_lcd_spi_decoder.sv
module tb_lcd_spi_decoder;

    localparam int HALF = 3;   // spi_clk half period in clk cycles

    logic        clk = 1'b0;
    logic        resn = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_dc = 1'b0;
    logic        spi_resn = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_dc;
    logic        pixel_valid;
    logic [7:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic [15:0] pixel_color;

    lcd_spi_decoder dut (
        .clk         (clk),
        .resn        (resn),
        .spi_csn     (spi_csn),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_dc      (spi_dc),
        .spi_resn    (spi_resn),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_dc     (byte_dc),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled away from the active edge.
    int          nbytes = 0;
    int          npix = 0;
    logic [7:0]  lb = '0;
    logic        ld = 1'b0;
    logic [7:0]  lx = '0;
    logic [7:0]  ly = '0;
    logic [15:0] lc = '0;

    always @(negedge clk) begin
        if (byte_valid) begin
            nbytes++;
            lb = byte_data;
            ld = byte_dc;
        end
        if (pixel_valid) begin
            npix++;
            lx = pixel_x;
            ly = pixel_y;
            lc = pixel_color;
        end
    end

    int last_lat = 0;

    // Sends the top nbits of data MSB first inside one chip-select frame.
    task automatic send_bits(input logic [7:0] data, input logic dc, input int nbits);
        logic [7:0] d;
        d = data;
        @(negedge clk);
        spi_csn = 1'b0;
        spi_dc  = dc;
        repeat (2) @(negedge clk);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = d[i];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            if (i == 0) begin
                last_lat = 0;
                for (int n = 1; n <= 6; n++) begin
                    @(negedge clk);
                    if (byte_valid && last_lat == 0) last_lat = n;
                end
            end else begin
                repeat (HALF) @(negedge clk);
            end
            spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic dc);
        send_bits(data, dc, 8);
    endtask

    task automatic send_pixel(input logic [15:0] color);
        send_byte(color[15:8], 1'b1);
        send_byte(color[7:0], 1'b1);
    endtask

    task automatic send_window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
        send_byte(op, 1'b0);
        send_byte(s[15:8], 1'b1);
        send_byte(s[7:0], 1'b1);
        send_byte(e[15:8], 1'b1);
        send_byte(e[7:0], 1'b1);
    endtask

    task automatic pulse_resn();
        @(negedge clk);
        resn = 1'b0;
        repeat (3) @(negedge clk);
        resn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    int exp_x[8] = '{10, 11, 12, 10, 11, 12, 10, 11};
    int exp_y[8] = '{20, 20, 20, 21, 21, 21, 20, 20};
    int p0;
    int b0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_byte_dc", 32'(byte_dc), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_pixel_x", 32'(pixel_x), 32'd0);
        check("rst_pixel_y", 32'(pixel_y), 32'd0);
        check("rst_pixel_color", 32'(pixel_color), 32'd0);
        resn = 1'b1;
        repeat (4) @(negedge clk);

        // Two plain bytes with latency measurement
        send_byte(8'hA5, 1'b0);
        check("b1_latency", 32'(last_lat), 32'd4);
        check("b1_count", 32'(nbytes), 32'd1);
        check("b1_data", 32'(lb), 32'hA5);
        check("b1_dc", 32'(ld), 32'd0);
        send_byte(8'h3C, 1'b1);
        check("b2_count", 32'(nbytes), 32'd2);
        check("b2_data", 32'(lb), 32'h3C);
        check("b2_dc", 32'(ld), 32'd1);

        // Window 10..12 x 20..21, eight pixels with wrap
        send_window(8'h2A, 16'd10, 16'd12);
        send_window(8'h2B, 16'd20, 16'd21);
        send_byte(8'h2C, 1'b0);
        p0 = npix;
        for (int i = 0; i < 8; i++) begin
            send_pixel(16'hF800);
            check($sformatf("win_cnt%0d", i), 32'(npix - p0), 32'(i + 1));
            check($sformatf("win_x%0d", i), 32'(lx), 32'(exp_x[i]));
            check($sformatf("win_y%0d", i), 32'(ly), 32'(exp_y[i]));
            check($sformatf("win_c%0d", i), 32'(lc), 32'hF800);
        end

        // Full-width row wrap after reset
        pulse_resn();
        send_byte(8'h2C, 1'b0);
        p0 = npix;
        for (int i = 0; i < 241; i++) begin
            send_pixel(16'h1000 + 16'(i));
            if (i == 0) begin
                check("row_x0", 32'(lx), 32'd0);
                check("row_y0", 32'(ly), 32'd0);
            end
            if (i == 239) begin
                check("row_x239", 32'(lx), 32'd239);
                check("row_y239", 32'(ly), 32'd0);
            end
        end
        check("row_cnt", 32'(npix - p0), 32'd241);
        check("row_x240", 32'(lx), 32'd0);
        check("row_y240", 32'(ly), 32'd1);
        check("row_c240", 32'(lc), 32'h10F0);

        // Aborted partial byte, then RAMWR
        b0 = nbytes;
        send_bits(8'hFF, 1'b0, 5);
        send_byte(8'h2C, 1'b0);
        check("part_count", 32'(nbytes - b0), 32'd1);
        check("part_data", 32'(lb), 32'h2C);
        check("part_dc", 32'(ld), 32'd0);
        p0 = npix;
        send_pixel(16'hABCD);
        check("part_pix_cnt", 32'(npix - p0), 32'd1);
        check("part_pix_x", 32'(lx), 32'd0);
        check("part_pix_y", 32'(ly), 32'd0);
        check("part_pix_c", 32'(lc), 32'hABCD);

        // Asynchronous reset in the middle of a pixel
        send_window(8'h2A, 16'd5, 16'd9);
        send_window(8'h2B, 16'd3, 16'd9);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'h8421);
        check("pre_rst_x", 32'(lx), 32'd5);
        send_byte(8'h77, 1'b1);
        @(posedge clk);
        #2 resn = 1'b0;
        #1;
        check("arst_byte_valid", 32'(byte_valid), 32'd0);
        check("arst_byte_data", 32'(byte_data), 32'd0);
        check("arst_byte_dc", 32'(byte_dc), 32'd0);
        check("arst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("arst_pixel_x", 32'(pixel_x), 32'd0);
        check("arst_pixel_y", 32'(pixel_y), 32'd0);
        check("arst_pixel_color", 32'(pixel_color), 32'd0);
        repeat (3) @(negedge clk);
        resn = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'h5555);
        check("arst_next_x", 32'(lx), 32'd0);
        check("arst_next_y", 32'(ly), 32'd0);
        check("arst_next_c", 32'(lc), 32'h5555);

        // Command mid-pixel clears the byte toggle
        send_byte(8'h2C, 1'b0);
        p0 = npix;
        send_byte(8'h12, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("nop_pix_cnt", 32'(npix - p0), 32'd1);
        check("nop_pix_c", 32'(lc), 32'h1234);
        check("nop_pix_x", 32'(lx), 32'd0);
        check("nop_pix_y", 32'(ly), 32'd0);

        // Display reset restores the default window
        send_window(8'h2A, 16'd7, 16'd9);
        @(negedge clk);
        spi_resn = 1'b0;
        repeat (8) @(negedge clk);
        spi_resn = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h2C, 1'b0);
        p0 = npix;
        send_pixel(16'h0F0F);
        check("dres_pix_cnt", 32'(npix - p0), 32'd1);
        check("dres_pix_x", 32'(lx), 32'd0);
        check("dres_pix_c", 32'(lc), 32'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_spi_decoder.md
LCD_SPI_DECODER -- requirements
Module: lcd_spi_decoder

Interface
REQ-001 SHALL have parameter c_x_size, default 240, meaning pixel X screen size.
REQ-002 SHALL have parameter c_y_size, default 240, meaning pixel Y screen size.
REQ-003 SHALL have parameter c_x_bits, default $clog2(c_x_size), meaning X output width.
REQ-004 SHALL have parameter c_y_bits, default $clog2(c_y_size), meaning Y output width.
REQ-005 SHALL have parameter c_sample_rising, default 1, meaning sample spi_mosi/spi_dc on spi_clk rising edge (0: falling).
REQ-006 SHALL have ports:
- clk, in, 1: system clock; at least 4x spi_clk frequency.
- resn, in, 1: asynchronous active-low reset.
- spi_csn, in, 1: chip select, active low.
- spi_clk, in, 1: SPI clock, asynchronous to clk.
- spi_mosi, in, 1: serial data, MSB first.
- spi_dc, in, 1: 0 = command, 1 = argument/data.
- spi_resn, in, 1: display reset, active low.
- byte_valid, out, 1: one-cycle strobe per received byte.
- byte_data, out, 8: received byte.
- byte_dc, out, 1: spi_dc sampled with bit 0 of the byte.
- pixel_valid, out, 1: one-cycle strobe per RGB565 pixel written.
- pixel_x, out, c_x_bits: pixel column.
- pixel_y, out, c_y_bits: pixel row.
- pixel_color, out, 16: RGB565 colour.

Function
REQ-007 SHALL pass spi_csn, spi_clk, spi_mosi, spi_dc and spi_resn through two-flop synchronizers and detect the sampling edge from the synchronized spi_clk.
REQ-008 SHALL, on each sampling edge while synchronized spi_csn=0, shift spi_mosi MSB-first into an 8-bit register and count bits 0..7.
REQ-009 SHALL, on the 8th bit, pulse byte_valid for exactly one clk with byte_data and byte_dc; latency from spi_clk pin edge to byte_valid = 4 clk.
REQ-010 SHALL discard a partial byte and clear the bit counter whenever synchronized spi_csn=1 or synchronized spi_resn=0.
REQ-011 SHALL run command FSM states IDLE, CASET, RASET, RAMWR, SKIP; any byte with dc=0 sets state by opcode: 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR, else SKIP, and clears the argument index and pixel byte toggle.
REQ-012 SHALL in CASET latch data bytes 0..3 as xs[15:8], xs[7:0], xe[15:8], xe[7:0], then ignore further data bytes (go to SKIP); RASET likewise for ys/ye.
REQ-013 SHALL, on entering RAMWR, set the write pointer (px,py) = (xs,ys).
REQ-014 SHALL in RAMWR treat data bytes as pairs: first byte = color[15:8], second = color[7:0]; pixel_valid pulses in the same cycle as byte_valid of the second byte, with pixel_x/pixel_y = current pointer (truncated to c_x_bits/c_y_bits).
REQ-015 SHALL advance the pointer after each pixel: if px==xe then px=xs and (if py==ye then py=ys else py=py+1), else px=px+1; 16-bit arithmetic, equality compare, wrap modulo 2^16.
REQ-016 SHALL ignore data bytes (dc=1) in IDLE and SKIP, still emitting byte_valid.
REQ-017 SHALL ignore 0x00 (NOP) as a command opcode only in that it enters SKIP; no other side effect.
REQ-018 SHALL keep FSM state, pointer and byte toggle across spi_csn deassertion (no reset of command context by CS).
REQ-019 SHALL hold pixel_x, pixel_y, pixel_color, byte_data, byte_dc stable between strobes.

Reset
REQ-020 SHALL, on resn=0 (asynchronous), set: byte_valid=0, byte_data=0, byte_dc=0, pixel_valid=0, pixel_x=0, pixel_y=0, pixel_color=0, state IDLE, xs=0, xe=c_x_size-1, ys=0, ye=c_y_size-1, px=py=0, toggle=0.
REQ-021 SHALL apply the same window/FSM/pointer defaults synchronously while synchronized spi_resn=0 (outputs keep last values, strobes 0).

Structure
REQ-022 SHALL take opcode constants (NOP 0x00, CASET 0x2A, RASET 0x2B, RAMWR 0x2C) and the FSM state enumeration from shared package lcd_pkg.
REQ-023 SHALL use one sub-module lcd_spi_byte_rx (synchronizers, edge detect, shifter, byte_valid/byte_data/byte_dc).

Verification
REQ-024 Bytes 0xA5 (dc=0), 0x3C (dc=1) -> two byte_valid strobes, byte_data/byte_dc = 0xA5/0, 0x3C/1.
REQ-025 CASET 0,10,0,12; RASET 0,20,0,21; RAMWR; 8 pixels 0xF800 -> pixel (x,y) = (10,20),(11,20),(12,20),(10,21),(11,21),(12,21),(10,20),(11,20).
REQ-026 After reset, RAMWR + 241 pixels -> pixel 240 at (0,1), colour as sent.
REQ-027 spi_csn raised after 5 bits, then full byte 0x2C -> one byte_valid 0x2C only, FSM enters RAMWR.
REQ-028 resn pulsed low mid-RAMWR -> all outputs 0 immediately; next RAMWR pixel at (0,0).
REQ-029 RAMWR, one byte 0x12, command 0x00, RAMWR, bytes 0x12 0x34 -> single pixel_color 0x1234 at (0,0).
